// File: rtl/timekeep_ctrl.sv
// timekeep_ctrl: mode FSM (clock / adjust time / adjust alarm / ring) driving time and alarm counter enables; alarm modes built only with TIMEKEEP_ALARM_EN.
// Latency: enables are combinational from registered state and current inputs (0 cycles); state, sel and ring count update on the next clk edge.
// Backpressure: none; every tick and button pulse is acted on in the cycle it arrives.
module timekeep_ctrl #(
    parameter int unsigned RING_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       sec_tc,
    input  logic       min_tc,
    input  logic       alarm_match,
    output logic       en_sec,
    output logic       en_min,
    output logic       en_hr,
    output logic       en_amin,
    output logic       en_ahr,
    output logic       sel,
    output logic [1:0] state,
    output logic       ringing
);
    localparam int unsigned CW = $clog2(RING_TICKS + 1);

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'd0,
        ST_ADJ_TIME  = 2'd1,
        ST_ADJ_ALARM = 2'd2,
        ST_RING      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] ring_cnt_q, ring_cnt_d;
    logic          any_btn, alarm_hit, ring_done, in_adj_d;

    assign any_btn   = btn_c | btn_l | btn_r | btn_u;
    assign ring_done = tick_1hz && (ring_cnt_q == CW'(RING_TICKS - 1));

`ifdef TIMEKEEP_ALARM_EN
    assign alarm_hit = tick_1hz & alarm_match;
`else
    logic unused_alarm_match;
    assign unused_alarm_match = alarm_match;
    assign alarm_hit          = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // btn_c always wins over a coincident alarm match or ring exit condition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLOCK: begin
                if (btn_c) begin
                    state_d = ST_ADJ_TIME;
                end else if (alarm_hit) begin
                    state_d = ST_RING;
                end
            end
            ST_ADJ_TIME: begin
                if (btn_c) begin
`ifdef TIMEKEEP_ALARM_EN
                    state_d = ST_ADJ_ALARM;
`else
                    state_d = ST_CLOCK;
`endif
                end
            end
            ST_ADJ_ALARM: begin
                if (btn_c) begin
                    state_d = ST_CLOCK;
                end
            end
            ST_RING: begin
                if (any_btn || ring_done) begin
                    state_d = ST_CLOCK;
                end
            end
        endcase
    end

    // sel restarts on minutes whenever an adjust mode is entered; L/R only steer it while staying put.
    always_comb begin
        in_adj_d = (state_d == ST_ADJ_TIME) || (state_d == ST_ADJ_ALARM);
        sel_d    = sel_q;
        if (in_adj_d && (state_d != state_q)) begin
            sel_d = 1'b0;
        end else if (in_adj_d && (btn_l != btn_r)) begin
            sel_d = btn_l;
        end
        ring_cnt_d = '0;
        if ((state_q == ST_RING) && (state_d == ST_RING)) begin
            ring_cnt_d = ring_cnt_q + CW'(tick_1hz);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= 1'b0;
            ring_cnt_q <= '0;
        end else begin
            sel_q      <= sel_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    always_comb begin
        en_sec  = 1'b0;
        en_min  = 1'b0;
        en_hr   = 1'b0;
        en_amin = 1'b0;
        en_ahr  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_ADJ_TIME: begin
                    // Time is frozen; a minute bump never carries into hours.
                    en_min = btn_u & ~sel_q & ~btn_c;
                    en_hr  = btn_u & sel_q & ~btn_c;
                end
                default: begin
                    en_sec = tick_1hz;
                    en_min = tick_1hz & sec_tc;
                    en_hr  = tick_1hz & sec_tc & min_tc;
                end
            endcase
`ifdef TIMEKEEP_ALARM_EN
            if (state_q == ST_ADJ_ALARM) begin
                en_amin = btn_u & ~sel_q & ~btn_c;
                en_ahr  = btn_u & sel_q & ~btn_c;
            end
`endif
        end
    end

`ifdef TIMEKEEP_ALARM_EN
    assign ringing = (state_q == ST_RING);
`else
    assign ringing = 1'b0;
`endif
    assign state = state_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_timekeep_ctrl.sv
// Bench for timekeep_ctrl: directed scenarios plus randomized stimulus, all outputs checked every cycle
// against a mode/counter reference model; works with TIMEKEEP_ALARM_EN defined or not.
module tb_timekeep_ctrl;
    localparam int RT = 4;
`ifdef TIMEKEEP_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif
    localparam logic [8:0] T   = 9'h001;
    localparam logic [8:0] C   = 9'h002;
    localparam logic [8:0] L   = 9'h004;
    localparam logic [8:0] R   = 9'h008;
    localparam logic [8:0] U   = 9'h010;
    localparam logic [8:0] STC = 9'h020;
    localparam logic [8:0] MTC = 9'h040;
    localparam logic [8:0] AM  = 9'h080;
    localparam logic [8:0] RST = 9'h100;

    logic clk = 1'b0, reset = 1'b1;
    logic tick_1hz = 1'b0, btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0;
    logic sec_tc = 1'b0, min_tc = 1'b0, alarm_match = 1'b0;
    logic en_sec, en_min, en_hr, en_amin, en_ahr, sel, ringing;
    logic [1:0] state;

    timekeep_ctrl #(.RING_TICKS(RT)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u),
        .sec_tc(sec_tc), .min_tc(min_tc), .alarm_match(alarm_match),
        .en_sec(en_sec), .en_min(en_min), .en_hr(en_hr),
        .en_amin(en_amin), .en_ahr(en_ahr), .sel(sel),
        .state(state), .ringing(ringing)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cnt_sec = 0, cnt_min = 0, cnt_hr = 0, cnt_amin = 0;
    // Reference model: mode 0 clock, 1 adjust time, 2 adjust alarm, 3 ringing; m_ring = ticks heard while ringing.
    int m_mode = 0;
    bit m_sel  = 1'b0;
    int m_ring = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic [8:0] v);
        tick_1hz = v[0]; btn_c = v[1]; btn_l = v[2]; btn_r = v[3]; btn_u = v[4];
        sec_tc = v[5]; min_tc = v[6]; alarm_match = v[7]; reset = v[8];
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 1'b0; m_ring = 0;
    endtask

    task automatic compare(input logic [8:0] v);
        bit live, frz, up;
        live = !v[8];
        frz  = (m_mode == 1);
        up   = v[4] && !v[1];
        chk("state",   int'(state),   m_mode);
        chk("sel",     int'(sel),     int'(m_sel));
        chk("ringing", int'(ringing), int'(m_mode == 3));
        chk("en_sec",  int'(en_sec),  int'(live && !frz && v[0]));
        chk("en_min",  int'(en_min),  int'(live && (frz ? (up && !m_sel) : (v[0] && v[5]))));
        chk("en_hr",   int'(en_hr),   int'(live && (frz ? (up && m_sel) : (v[0] && v[5] && v[6]))));
        chk("en_amin", int'(en_amin), int'(live && m_mode == 2 && up && !m_sel));
        chk("en_ahr",  int'(en_ahr),  int'(live && m_mode == 2 && up && m_sel));
    endtask

    task automatic model_step(input logic [8:0] v);
        int nm, nr;
        bit ns;
        if (v[8]) return;
        nm = m_mode; ns = m_sel; nr = m_ring;
        case (m_mode)
            0: begin
                if (v[1]) begin nm = 1; ns = 1'b0; end
                else if (ALARM && v[0] && v[7]) begin nm = 3; nr = 0; end
            end
            1, 2: begin
                if (v[1]) begin
                    nm = (m_mode == 1 && ALARM) ? 2 : 0;
                    if (nm == 2) ns = 1'b0;
                end else if (v[2] != v[3]) begin
                    ns = v[2];
                end
            end
            default: begin
                if (v[0]) nr = nr + 1;
                if (v[1] || v[2] || v[3] || v[4] || nr == RT) nm = 0;
            end
        endcase
        m_mode = nm; m_sel = ns; m_ring = nr;
    endtask

    // One clock cycle: apply v, check every output mid-cycle, then advance the model across the edge.
    task automatic cyc(input logic [8:0] v);
        @(posedge clk);
        #1;
        drive(v);
        if (v[8]) model_reset();
        @(negedge clk);
        compare(v);
        cnt_sec += int'(en_sec); cnt_min += int'(en_min);
        cnt_hr += int'(en_hr); cnt_amin += int'(en_amin);
        model_step(v);
    endtask

    // Assert reset asynchronously in the middle of a cycle and check it takes effect at once.
    task automatic reset_now();
        @(posedge clk);
        #1;
        drive(9'h000);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst state", int'(state), 0);
        chk("async rst ringing", int'(ringing), 0);
        chk("async rst sel", int'(sel), 0);
        model_reset();
    endtask

    initial begin
        int s_sec, s_min, s_hr, s_amin;
        logic [8:0] v;
        drive(RST);
        cyc(RST | T | STC | MTC | U);
        chk("reset en_sec", int'(en_sec), 0);
        chk("reset en_hr", int'(en_hr), 0);
        chk("reset state", int'(state), 0);
        cyc(RST);
        cyc(9'h000);

        s_sec = cnt_sec; s_min = cnt_min;
        for (int i = 0; i < 3; i++) begin cyc(T); cyc(9'h000); end
        chk("3 ticks en_sec", cnt_sec - s_sec, 3);
        chk("3 ticks en_min", cnt_min - s_min, 0);
        chk("3 ticks state", int'(state), 0);

        cyc(T | STC | MTC);
        chk("carry en_sec", int'(en_sec), 1);
        chk("carry en_min", int'(en_min), 1);
        chk("carry en_hr", int'(en_hr), 1);

        s_sec = cnt_sec; s_min = cnt_min; s_hr = cnt_hr;
        cyc(C); cyc(L); cyc(U); cyc(U | T); cyc(R); cyc(U | STC | MTC | T); cyc(T); cyc(9'h000);
        chk("adj state", int'(state), 1);
        chk("adj en_hr pulses", cnt_hr - s_hr, 2);
        chk("adj en_min pulses", cnt_min - s_min, 1);
        chk("adj en_sec pulses", cnt_sec - s_sec, 0);
        chk("model adj mode", m_mode, 1);

`ifdef TIMEKEEP_ALARM_EN
        s_amin = cnt_amin;
        cyc(L); cyc(C); cyc(U);
        chk("aadj state", int'(state), 2);
        chk("aadj en_amin", int'(en_amin), 1);
        chk("aadj en_ahr", int'(en_ahr), 0);
        cyc(C | U);
        chk("aadj exit en_amin", int'(en_amin), 0);
        chk("aadj exit en_ahr", int'(en_ahr), 0);
        cyc(9'h000);
        chk("aadj exit state", int'(state), 0);
        chk("aadj amin pulses", cnt_amin - s_amin, 1);

        cyc(T | AM | C); cyc(9'h000);
        chk("btn_c beats alarm", int'(state), 1);
        cyc(C); cyc(C); cyc(9'h000);
        chk("back to clock", int'(state), 0);

        cyc(T | AM); cyc(9'h000);
        chk("ring state", int'(state), 3);
        chk("ring ringing", int'(ringing), 1);
        chk("model ring mode", m_mode, 3);
        for (int i = 0; i < 3; i++) begin cyc(T); cyc(9'h000); end
        chk("ring 3 ticks state", int'(state), 3);
        cyc(T); cyc(9'h000);
        chk("ring timeout state", int'(state), 0);
        chk("ring timeout ringing", int'(ringing), 0);

        cyc(T | AM); cyc(T); cyc(T); cyc(U);
        chk("ring btn_u en_min", int'(en_min), 0);
        chk("ring btn_u ringing", int'(ringing), 1);
        cyc(9'h000);
        chk("ring btn_u exit", int'(state), 0);

        cyc(T | AM); cyc(T); cyc(T);
        reset_now();
        cyc(RST); cyc(9'h000);
        cyc(U);
        chk("post-reset en_min", int'(en_min), 0);
        chk("post-reset state", int'(state), 0);
        cyc(T | AM); cyc(9'h000);
        for (int i = 0; i < 3; i++) begin cyc(T); cyc(9'h000); end
        chk("ring restart count", int'(state), 3);
        cyc(U); cyc(9'h000);
`else
        s_amin = cnt_amin;
        cyc(U); cyc(C); cyc(9'h000);
        chk("adj exit state", int'(state), 0);
        chk("no alarm en_amin", cnt_amin - s_amin, 0);
        cyc(C); cyc(9'h000);
        chk("btn_c once", int'(state), 1);
        cyc(C); cyc(9'h000);
        chk("btn_c twice", int'(state), 0);
        cyc(T | AM); cyc(9'h000);
        chk("alarm ignored state", int'(state), 0);
        chk("alarm ignored ringing", int'(ringing), 0);
        cyc(C); cyc(T); reset_now();
        cyc(RST); cyc(U);
        chk("post-reset en_min", int'(en_min), 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            int b;
            v = 9'h000;
            if ($urandom_range(0, 2) == 0) v |= T;
            if ($urandom_range(0, 1) == 0) v |= STC;
            if ($urandom_range(0, 1) == 0) v |= MTC;
            if ($urandom_range(0, 3) == 0) v |= AM;
            b = int'($urandom_range(0, 15));
            case (b)
                0: v |= C;
                1: v |= L;
                2: v |= R;
                3, 4: v |= U;
                5: v |= C | U;
                6: v |= L | R;
                7: v |= L | U;
                default: ;
            endcase
            if ($urandom_range(0, 199) == 0) v |= RST;
            cyc(v);
        end
        cyc(9'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
